// File: rtl/raster_quad_dispatch_pkg.sv
// Raster stamp/CSR types plus the dispatch state enum and the stamp-to-CSR packing helper
// shared by the quad dispatch block.
package raster_quad_dispatch_pkg;

    localparam int RASTER_DIM_BITS = 15;
    localparam int RASTER_PID_BITS = 4;

    localparam int RASTER_POSX_LSB = 4;
    localparam int RASTER_POSY_LSB = 4 + RASTER_DIM_BITS - 1;

    typedef struct packed {
        logic [RASTER_DIM_BITS-2:0] pos_x;
        logic [RASTER_DIM_BITS-2:0] pos_y;
        logic [3:0]                 mask;
        logic [2:0][3:0][31:0]      bcoords;
        logic [RASTER_PID_BITS-1:0] pid;
    } raster_stamp_t;

    typedef struct packed {
        logic [31:0]           pos_mask;
        logic [2:0][3:0][31:0] bcoords;
    } raster_csrs_t;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        RESPOND
    } raster_dispatch_state_t;

    // The primitive id is not visible to shaders, so it is dropped here.
    function automatic raster_csrs_t stamp_to_csrs(input raster_stamp_t stamp);
        raster_csrs_t csrs;
        csrs          = '0;
        csrs.bcoords  = stamp.bcoords;
        csrs.pos_mask[3:0] = stamp.mask;
        csrs.pos_mask[RASTER_POSX_LSB +: RASTER_DIM_BITS-1] = stamp.pos_x;
        csrs.pos_mask[RASTER_POSY_LSB +: RASTER_DIM_BITS-1] = stamp.pos_y;
        return csrs;
    endfunction

endpackage

// File: rtl/raster_quad_dispatch_if.sv
// Bundle of stamp-in, warp-request and response handshakes around the quad dispatcher.
interface raster_quad_dispatch_if
    import raster_quad_dispatch_pkg::*;
#(
    parameter int NUM_LANES = 4,
    parameter int TAG_BITS  = 8
) ();

    logic                                       stamp_valid;
    raster_stamp_t                              stamp_data;
    logic                                       stamp_ready;
    logic                                       raster_done;

    logic                                       req_valid;
    logic [NUM_LANES-1:0]                       req_tmask;
    logic [TAG_BITS-1:0]                        req_tag;
    logic                                       req_ready;

    logic                                       rsp_valid;
    logic [NUM_LANES-1:0]                       rsp_tmask;
    logic [TAG_BITS-1:0]                        rsp_tag;
    logic [NUM_LANES*$bits(raster_csrs_t)-1:0]  rsp_csrs;
    logic                                       rsp_ready;

    modport master (
        output stamp_valid, stamp_data, raster_done,
        output req_valid, req_tmask, req_tag,
        output rsp_ready,
        input  stamp_ready, req_ready,
        input  rsp_valid, rsp_tmask, rsp_tag, rsp_csrs
    );

    modport slave (
        input  stamp_valid, stamp_data, raster_done,
        input  req_valid, req_tmask, req_tag,
        input  rsp_ready,
        output stamp_ready, req_ready,
        output rsp_valid, rsp_tmask, rsp_tag, rsp_csrs
    );

endinterface

// File: rtl/raster_quad_dispatch_stamp_fifo.sv
// Synchronous FIFO of raster stamps; the ready flag is registered so it reads low
// during reset and stays low for the whole cycle in which the FIFO is full.
module raster_stamp_fifo
    import raster_quad_dispatch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push_valid_i,
    input  raster_stamp_t push_data_i,
    output logic          push_ready_o,
    input  logic          pop_i,
    output raster_stamp_t pop_data_o,
    output logic          empty_o
);

    localparam int PTR_BITS = $clog2(DEPTH);
    localparam logic [PTR_BITS:0] FULL_COUNT = DEPTH[PTR_BITS:0];

    raster_stamp_t         mem_q [DEPTH];
    logic [PTR_BITS-1:0]   wr_ptr_q;
    logic [PTR_BITS-1:0]   rd_ptr_q;
    logic [PTR_BITS:0]     count_q;
    logic [PTR_BITS:0]     count_d;
    logic                  ready_q;
    logic                  push;
    logic                  pop;

    assign push         = push_valid_i && ready_q;
    assign pop          = pop_i && (count_q != '0);
    assign push_ready_o = ready_q;
    assign empty_o      = (count_q == '0);
    assign pop_data_o   = mem_q[rd_ptr_q];

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!push && pop) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ready_q  <= 1'b0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
            ready_q <= (count_d != FULL_COUNT);
        end
    end

endmodule

// File: rtl/raster_quad_dispatch.sv
// Hands buffered raster quads to warp fetch requests, one quad per active lane,
// zero-filling lanes once the rasterizer reports there is no more work.
module raster_quad_dispatch
    import raster_quad_dispatch_pkg::*;
#(
    parameter int NUM_LANES   = 4,
    parameter int STAMP_DEPTH = 4,
    parameter int TAG_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    raster_quad_dispatch_if.slave bus
);

    raster_dispatch_state_t          state_q;
    logic                            req_ready_q;
    logic                            rsp_valid_q;
    logic [NUM_LANES-1:0]            tmask_q;
    logic [TAG_BITS-1:0]             tag_q;
    logic [NUM_LANES-1:0]            pending_q;
    logic [NUM_LANES-1:0]            pending_d;
    logic [NUM_LANES-1:0]            target_oh;
    raster_csrs_t [NUM_LANES-1:0]    slots_q;
    raster_stamp_t                   head;
    logic                            fifo_empty;
    logic                            pop;

    raster_stamp_fifo #(
        .DEPTH (STAMP_DEPTH)
    ) u_fifo (
        .clk          (clk),
        .reset        (reset),
        .push_valid_i (bus.stamp_valid),
        .push_data_i  (bus.stamp_data),
        .push_ready_o (bus.stamp_ready),
        .pop_i        (pop),
        .pop_data_o   (head),
        .empty_o      (fifo_empty)
    );

    // Lowest pending lane is served first so quads land in lane order.
    assign target_oh = pending_q & (~pending_q + 1'b1);
    assign pop       = (state_q == COLLECT) && !fifo_empty;

    always_comb begin
        pending_d = pending_q;
        if (state_q == COLLECT) begin
            if (!fifo_empty) begin
                pending_d = pending_q & ~target_oh;
            end else if (bus.raster_done) begin
                pending_d = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            tmask_q     <= '0;
            tag_q       <= '0;
            pending_q   <= '0;
            slots_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    req_ready_q <= 1'b1;
                    if (bus.req_valid && req_ready_q) begin
                        tmask_q     <= bus.req_tmask;
                        tag_q       <= bus.req_tag;
                        pending_q   <= bus.req_tmask;
                        slots_q     <= '0;
                        req_ready_q <= 1'b0;
                        if (bus.req_tmask != '0) begin
                            state_q <= COLLECT;
                        end else begin
                            state_q     <= RESPOND;
                            rsp_valid_q <= 1'b1;
                        end
                    end
                end
                COLLECT: begin
                    pending_q <= pending_d;
                    for (int i = 0; i < NUM_LANES; i++) begin
                        if (pop && target_oh[i]) begin
                            slots_q[i] <= stamp_to_csrs(head);
                        end
                    end
                    if (pending_d == '0) begin
                        state_q     <= RESPOND;
                        rsp_valid_q <= 1'b1;
                    end
                end
                RESPOND: begin
                    if (bus.rsp_ready) begin
                        state_q     <= IDLE;
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_tmask = tmask_q;
    assign bus.rsp_tag   = tag_q;
    assign bus.rsp_csrs  = slots_q;

endmodule

// File: tb/tb_raster_quad_dispatch.sv
// Directed bench for raster_quad_dispatch: preload stamps, issue warp requests and
// compare every lane against hand-built expected CSR words.
module tb_raster_quad_dispatch;
    import raster_quad_dispatch_pkg::*;

    localparam int NUM_LANES   = 4;
    localparam int STAMP_DEPTH = 4;
    localparam int TAG_BITS    = 8;
    localparam int CW          = $bits(raster_csrs_t);

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   vecCount  = 0;
    int   missCount = 0;

    raster_quad_dispatch_if #(.NUM_LANES(NUM_LANES), .TAG_BITS(TAG_BITS)) bus ();

    raster_quad_dispatch #(
        .NUM_LANES   (NUM_LANES),
        .STAMP_DEPTH (STAMP_DEPTH),
        .TAG_BITS    (TAG_BITS)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [511:0] observed, input logic [511:0] expected);
        vecCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic logic [2:0][3:0][31:0] patternFor(input int idx);
        logic [2:0][3:0][31:0] b;
        for (int j = 0; j < 3; j++) begin
            for (int k = 0; k < 4; k++) begin
                b[j][k] = 32'hBC00_0000 | (32'(idx) << 8) | (32'(j) << 4) | 32'(k);
            end
        end
        return b;
    endfunction

    function automatic raster_stamp_t makeStamp(input int idx, input int mask, input int px, input int py);
        raster_stamp_t s;
        s.pos_x   = px[RASTER_DIM_BITS-2:0];
        s.pos_y   = py[RASTER_DIM_BITS-2:0];
        s.mask    = mask[3:0];
        s.pid     = idx[RASTER_PID_BITS-1:0];
        s.bcoords = patternFor(idx);
        return s;
    endfunction

    // Expected CSR word: mask in bits 3:0, x from bit 4, y from bit 18.
    function automatic raster_csrs_t expCsrs(input int idx, input int mask, input int px, input int py);
        raster_csrs_t e;
        e.pos_mask = 32'(mask) | (32'(px) << 4) | (32'(py) << 18);
        e.bcoords  = patternFor(idx);
        return e;
    endfunction

    function automatic raster_csrs_t laneOf(input int lane);
        return bus.rsp_csrs[lane*CW +: CW];
    endfunction

    task automatic pushStamp(input raster_stamp_t s);
        int guard;
        guard = 0;
        bus.stamp_valid = 1'b1;
        bus.stamp_data  = s;
        while (!bus.stamp_ready && guard < 50) begin
            tick();
            guard++;
        end
        if (guard >= 50) checkOutput("push_timeout", 512'(bus.stamp_ready), 512'(1));
        tick();
        bus.stamp_valid = 1'b0;
    endtask

    task automatic applyStimulus(input logic [NUM_LANES-1:0] tmask, input logic [TAG_BITS-1:0] tag);
        int guard;
        guard = 0;
        bus.req_valid = 1'b1;
        bus.req_tmask = tmask;
        bus.req_tag   = tag;
        while (!bus.req_ready && guard < 50) begin
            tick();
            guard++;
        end
        if (guard >= 50) checkOutput("req_timeout", 512'(bus.req_ready), 512'(1));
        tick();
        bus.req_valid = 1'b0;
    endtask

    task automatic waitRsp(output int lat);
        lat = 1;
        while (!bus.rsp_valid && lat < 60) begin
            tick();
            lat++;
        end
    endtask

    task automatic rspHandshake();
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, vectors %0d", vecCount);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int lat;
        logic sawValid;

        bus.stamp_valid = 1'b0;
        bus.stamp_data  = '0;
        bus.raster_done = 1'b0;
        bus.req_valid   = 1'b0;
        bus.req_tmask   = '0;
        bus.req_tag     = '0;
        bus.rsp_ready   = 1'b0;

        tick();
        tick();
        checkOutput("rst_stamp_ready_held", 512'(bus.stamp_ready), 512'(0));
        reset = 1'b0;
        tick();
        checkOutput("rst_stamp_ready", 512'(bus.stamp_ready), 512'(1));
        checkOutput("rst_req_ready", 512'(bus.req_ready), 512'(1));
        checkOutput("rst_rsp_valid", 512'(bus.rsp_valid), 512'(0));
        checkOutput("rst_rsp_tag_tmask", 512'({bus.rsp_tag, bus.rsp_tmask}), 512'(0));
        checkOutput("rst_lane0", 512'(laneOf(0)), 512'(0));

        // Four quads, four active lanes.
        for (int i = 0; i < 4; i++) pushStamp(makeStamp(i, i + 1, i + 1, 7));
        applyStimulus(4'b1111, 8'h5A);
        waitRsp(lat);
        checkOutput("t1_latency", 512'(lat), 512'(5));
        for (int i = 0; i < 4; i++) checkOutput($sformatf("t1_lane%0d", i), 512'(laneOf(i)), 512'(expCsrs(i, i + 1, i + 1, 7)));
        checkOutput("t1_tag", 512'(bus.rsp_tag), 512'(8'h5A));
        checkOutput("t1_tmask", 512'(bus.rsp_tmask), 512'(4'b1111));
        rspHandshake();
        checkOutput("t1_rsp_drop", 512'(bus.rsp_valid), 512'(0));
        checkOutput("t1_req_ready", 512'(bus.req_ready), 512'(1));

        // Sparse mask: only lanes 1 and 3 consume quads.
        pushStamp(makeStamp(10, 5, 100, 200));
        pushStamp(makeStamp(11, 9, 300, 400));
        applyStimulus(4'b1010, 8'h11);
        waitRsp(lat);
        checkOutput("t2_latency", 512'(lat), 512'(3));
        checkOutput("t2_lane0", 512'(laneOf(0)), 512'(0));
        checkOutput("t2_lane1", 512'(laneOf(1)), 512'(expCsrs(10, 5, 100, 200)));
        checkOutput("t2_lane2", 512'(laneOf(2)), 512'(0));
        checkOutput("t2_lane3", 512'(laneOf(3)), 512'(expCsrs(11, 9, 300, 400)));
        rspHandshake();

        // End of work with one quad left; max coordinates fill pos_mask completely.
        pushStamp(makeStamp(20, 15, 16383, 16383));
        bus.raster_done = 1'b1;
        applyStimulus(4'b1111, 8'h22);
        waitRsp(lat);
        checkOutput("t3_latency", 512'(lat), 512'(3));
        checkOutput("t3_lane0_posmask", 512'(laneOf(0).pos_mask), 512'(32'hFFFF_FFFF));
        checkOutput("t3_lane0", 512'(laneOf(0)), 512'(expCsrs(20, 15, 16383, 16383)));
        for (int i = 1; i < 4; i++) checkOutput($sformatf("t3_lane%0d_zero", i), 512'(laneOf(i)), 512'(0));
        rspHandshake();
        bus.raster_done = 1'b0;

        // Starved request waits, then completes once stamps arrive; response holds under backpressure.
        applyStimulus(4'b0011, 8'h77);
        sawValid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            sawValid = sawValid | bus.rsp_valid;
            tick();
        end
        checkOutput("t4_no_rsp", 512'(sawValid), 512'(0));
        pushStamp(makeStamp(30, 3, 12, 34));
        pushStamp(makeStamp(31, 6, 56, 78));
        checkOutput("t4_not_yet", 512'(bus.rsp_valid), 512'(0));
        tick();
        checkOutput("t4_rsp_3_after_push", 512'(bus.rsp_valid), 512'(1));
        for (int c = 0; c < 5; c++) begin
            checkOutput($sformatf("t4_hold%0d_valid", c), 512'({bus.rsp_valid, bus.req_ready}), 512'(2'b10));
            checkOutput($sformatf("t4_hold%0d_lane0", c), 512'(laneOf(0)), 512'(expCsrs(30, 3, 12, 34)));
            checkOutput($sformatf("t4_hold%0d_lane1", c), 512'(laneOf(1)), 512'(expCsrs(31, 6, 56, 78)));
            checkOutput($sformatf("t4_hold%0d_tag", c), 512'({bus.rsp_tag, bus.rsp_tmask}), 512'({8'h77, 4'b0011}));
            tick();
        end
        rspHandshake();

        // Overfill: only four of six back-to-back pushes land.
        bus.stamp_valid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            bus.stamp_data = makeStamp(40 + k, k + 1, k, k);
            checkOutput($sformatf("t5_ready_k%0d", k), 512'(bus.stamp_ready), 512'(k < 4));
            tick();
        end
        bus.stamp_valid = 1'b0;
        applyStimulus(4'b0001, 8'h44);
        checkOutput("t5_ready_in_pop_cycle", 512'(bus.stamp_ready), 512'(0));
        tick();
        checkOutput("t5_ready_after_pop", 512'(bus.stamp_ready), 512'(1));
        checkOutput("t5_rsp_valid", 512'(bus.rsp_valid), 512'(1));
        checkOutput("t5_lane0", 512'(laneOf(0)), 512'(expCsrs(40, 1, 0, 0)));
        rspHandshake();

        // Reset in COLLECT with three quads buffered.
        applyStimulus(4'b1111, 8'h99);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("t6_async_stamp_ready", 512'(bus.stamp_ready), 512'(0));
        checkOutput("t6_async_req_ready", 512'(bus.req_ready), 512'(0));
        checkOutput("t6_async_rsp_valid", 512'(bus.rsp_valid), 512'(0));
        checkOutput("t6_async_tag_tmask", 512'({bus.rsp_tag, bus.rsp_tmask}), 512'(0));
        for (int i = 0; i < 4; i++) checkOutput($sformatf("t6_async_lane%0d", i), 512'(laneOf(i)), 512'(0));
        tick();
        tick();
        reset = 1'b0;
        tick();
        checkOutput("t6_req_ready", 512'(bus.req_ready), 512'(1));
        checkOutput("t6_stamp_ready", 512'(bus.stamp_ready), 512'(1));
        applyStimulus(4'b0000, 8'h33);
        checkOutput("t6_zero_mask_rsp", 512'(bus.rsp_valid), 512'(1));
        checkOutput("t6_zero_mask_tag", 512'(bus.rsp_tag), 512'(8'h33));
        for (int i = 0; i < 4; i++) checkOutput($sformatf("t6_zero_lane%0d", i), 512'(laneOf(i)), 512'(0));
        rspHandshake();
        bus.raster_done = 1'b1;
        applyStimulus(4'b0001, 8'h34);
        waitRsp(lat);
        checkOutput("t6_fifo_flushed_latency", 512'(lat), 512'(2));
        checkOutput("t6_fifo_flushed_lane0", 512'(laneOf(0)), 512'(0));
        rspHandshake();
        bus.raster_done = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
